// File: rtl/simon_host_if_pkg.sv
// Shared command codes, FSM state encoding and byte-count helpers for the
// SIMON host front end.
package simon_host_if_pkg;

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] CMD_DEC = 8'h44;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RX_KEY,
        ST_RX_BLK,
        ST_KEY_REQ,
        ST_KEY_WAIT,
        ST_DAT_REQ,
        ST_DAT_WAIT,
        ST_ACK,
        ST_TX
    } state_t;

    // Bytes in a 2N-bit block
    function automatic int unsigned block_bytes(input int unsigned n);
        return (2 * n) / 8;
    endfunction

    // Bytes in an M*N-bit key
    function automatic int unsigned key_bytes(input int unsigned n, input int unsigned m);
        return (m * n) / 8;
    endfunction

endpackage

// File: rtl/simon_host_if_if.sv
// Host-side valid/ready byte channel plus error pulse.
interface simon_host_if_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       err;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_byte, err
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_byte, err
    );
endinterface

// File: rtl/simon_host_if_tx_ser.sv
// Result serializer: loads a W-bit word and emits it LS byte first over a
// valid/ready channel; out_byte holds while the consumer stalls.
module simon_host_if_tx_ser #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [7:0]   out_byte,
    output logic         last_c
);

    localparam int unsigned NB   = W / 8;
    localparam int unsigned CNT_W = $clog2(NB + 1);

    logic [W-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            sh_d    = data;
            cnt_d   = CNT_W'(NB);
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            sh_d    = {8'h00, sh_q[W-1:8]};
            cnt_d   = cnt_q - CNT_W'(1);
            valid_d = (cnt_q != CNT_W'(1));
        end
    end

    assign out_valid = valid_q;
    assign out_byte  = sh_q[7:0];
    assign last_c    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/simon_host_if.sv
// Framed byte-stream front end for the SIMON core: parses K/E/D commands,
// runs the newKey/newData/readData handshakes and streams the result back.
module simon_host_if
    import simon_host_if_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned M = 4
) (
    input  logic                 clk,
    input  logic                 R,
    simon_host_if_if.slave       host,
    output logic                 newKey,
    output logic                 newData,
    output logic                 enc_dec,
    output logic                 readData,
    output logic [M-1:0][N-1:0]  key,
    output logic [2*N-1:0]       plain,
    input  logic                 ldKey,
    input  logic                 doneKey,
    input  logic                 ldData,
    input  logic                 doneData,
    input  logic [2*N-1:0]       cipher
);

    localparam int unsigned BB    = block_bytes(N);
    localparam int unsigned KB    = key_bytes(N, M);
    localparam int unsigned CNT_W = (KB > 1) ? $clog2(KB) : 1;
    localparam int unsigned KEY_W = M * N;
    localparam int unsigned BLK_W = 2 * N;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_ok_q, key_ok_d;
    logic               enc_dec_q, enc_dec_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               err_q, err_d;
    logic               new_key_q, new_key_d;
    logic               new_data_q, new_data_d;
    logic               read_data_q, read_data_d;
    logic               ser_load;
    logic               ser_valid;
    logic [7:0]         ser_byte;
    logic               ser_last_c;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = host.in_valid && in_ready_q;
    assign out_xfer = ser_valid && host.out_ready;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_ok_q    <= 1'b0;
            enc_dec_q   <= 1'b0;
            key_q       <= '0;
            blk_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            new_key_q   <= 1'b0;
            new_data_q  <= 1'b0;
            read_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_ok_q    <= key_ok_d;
            enc_dec_q   <= enc_dec_d;
            key_q       <= key_d;
            blk_q       <= blk_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
            new_key_q   <= new_key_d;
            new_data_q  <= new_data_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state and datapath; registered outputs are decoded from state_d.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_ok_d  = key_ok_q;
        enc_dec_d = enc_dec_q;
        key_d     = key_q;
        blk_d     = blk_q;
        res_d     = res_q;
        err_d     = 1'b0;
        ser_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    case (host.in_byte)
                        CMD_KEY: state_d = ST_RX_KEY;
                        CMD_ENC: begin
                            enc_dec_d = 1'b1;
                            state_d   = ST_RX_BLK;
                        end
                        CMD_DEC: begin
                            enc_dec_d = 1'b0;
                            state_d   = ST_RX_BLK;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_RX_KEY: begin
                if (in_xfer) begin
                    // Shift in from the top so the first byte lands in [7:0]
                    key_d = {host.in_byte, key_q[KEY_W-1:8]};
                    if (cnt_q == CNT_W'(KB - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_KEY_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RX_BLK: begin
                if (in_xfer) begin
                    blk_d = {host.in_byte, blk_q[BLK_W-1:8]};
                    if (cnt_q == CNT_W'(BB - 1)) begin
                        cnt_d = '0;
                        if (key_ok_q) begin
                            state_d = ST_DAT_REQ;
                        end else begin
                            err_d   = 1'b1;
                            blk_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_KEY_REQ: begin
                if (ldKey) begin
                    key_ok_d = 1'b0;
                    state_d  = ST_KEY_WAIT;
                end
            end
            ST_KEY_WAIT: begin
                if (doneKey) begin
                    key_ok_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DAT_REQ: begin
                if (ldData) state_d = ST_DAT_WAIT;
            end
            ST_DAT_WAIT: begin
                if (doneData) begin
                    res_d   = cipher;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!doneData) begin
                    ser_load = 1'b1;
                    state_d  = ST_TX;
                end
            end
            ST_TX: begin
                if (out_xfer && ser_last_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RX_KEY) || (state_d == ST_RX_BLK);
        new_key_d   = (state_d == ST_KEY_REQ);
        new_data_d  = (state_d == ST_DAT_REQ);
        read_data_d = (state_d == ST_ACK);
    end

    simon_host_if_tx_ser #(
        .W (BLK_W)
    ) u_tx_ser (
        .clk       (clk),
        .rst       (R),
        .load      (ser_load),
        .data      (res_q),
        .out_ready (host.out_ready),
        .out_valid (ser_valid),
        .out_byte  (ser_byte),
        .last_c    (ser_last_c)
    );

    assign host.in_ready  = in_ready_q;
    assign host.err       = err_q;
    assign host.out_valid = ser_valid;
    assign host.out_byte  = ser_byte;

    assign newKey   = new_key_q;
    assign newData  = new_data_q;
    assign readData = read_data_q;
    assign enc_dec  = enc_dec_q;
    assign key      = key_q;
    assign plain    = blk_q;

endmodule
